alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter and sequencer for the shared ALU. It accepts operation requests from three requesters: manual switches (0), CPU core (1) and UART command parser (2). It issues one operation at a time to the ALU, returns the 16-bit result to the winner, and optionally forwards the low result byte to the UART TX path over a valid/ready handshake with a timeout. It replaces the static mode-select SWITCH plus ena muxing in the top level.

## Interface
Parameters:
- `TX_MASK`, default 3'b110: bit i set means requester i's result is forwarded to TX.
- `TX_TIMEOUT`, default 1023: maximum cycles spent waiting for `tx_ready` before dropping the byte; range 1..1023.

Ports:
- `clock` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `ena` input 1: when low, no new grants; an operation already in flight completes.
- `req` input 3: request bit i from requester i. It is level-held until `gnt[i]`.
- `req_a` input 24: operand A; bits [8i+7:8i] belong to requester i.
- `req_b` input 24: operand B, same packing as `req_a`.
- `req_op` input 9: opcode; bits [3i+2:3i] belong to requester i.
- `gnt` output 3: one-cycle grant pulse; operands were captured.
- `done` output 3: one-cycle pulse; `result` is valid for that requester.
- `result` output 16: last ALU result; held until the next capture.
- `alu_a` output 8: registered operand to the ALU.
- `alu_b` output 8: registered operand to the ALU.
- `alu_opcode` output 3: registered opcode to the ALU.
- `alu_ena` output 1: high only in EXEC.
- `alu_result` input 16: combinational ALU output.
- `tx_valid` output 1: byte offered to TX.
- `tx_data` output 8: equals `result[7:0]` while `tx_valid` is high.
- `tx_ready` input 1: TX accepts the byte when high together with `tx_valid`.
- `tx_drop` output 1: one-cycle pulse on TX timeout.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP, SEND.
- IDLE
  - If `ena` is high and `req` is nonzero at an edge, pick the winner w.
  - Search order is `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - Latch `req_a`, `req_b` and `req_op` slices for w into the `alu_*` registers.
  - Register `gnt[w]=1`, set `ptr` to (w+1) mod 3, go to EXEC.
- EXEC
  - `alu_ena=1`.
  - At the edge, latch `alu_result` into `result`, go to RESP.
- RESP
  - `done[w]=1`.
  - If `TX_MASK[w]`: load the timeout counter with 0 and go to SEND; otherwise go to IDLE.
- SEND
  - `tx_valid=1`, `tx_data=result[7:0]`.
  - If `tx_ready` is high: go to IDLE.
  - Else if the counter equals `TX_TIMEOUT-1`: pulse `tx_drop`, go to IDLE.
  - Else increment the counter.
- Operand registers hold their values outside EXEC; the ALU sees stable inputs. `alu_ena` is 0 in every state except EXEC.
- `req` bits still high in IDLE after a grant count as new requests. Requesters must drop `req` in the cycle `gnt` is seen if they want only one operation.
- `ena` low in IDLE keeps the block in IDLE. `ena` is ignored in the other states.
- `result` width is 16 bits, with no truncation. `tx_data` is the low byte only.
- Reset from any state:
  - Next cycle the state is IDLE and `ptr=0`.
  - All outputs are 0, including `result`, the `alu_*` operand registers and the counter.
  - The in-flight operation is aborted: no `done`, no `tx_valid`.

## Timing
- Request sampled at edge E0 (IDLE) leads to:
  - `gnt` and `alu_ena` high in cycle E0..E1;
  - `result` updated at E1;
  - `done` high in cycle E1..E2;
  - `tx_valid` from E2, if masked.
- Non-TX throughput: one operation per 3 cycles. The next grant is sampled at E3 at the earliest, because IDLE is entered at E2.
- TX path:
  - Handshake completes at the first edge with `tx_valid & tx_ready`, and the state is IDLE at that edge.
  - `tx_ready` already high at entry to SEND means `tx_valid` is high for exactly 1 cycle.
  - Timeout: `tx_valid` is high for exactly `TX_TIMEOUT` cycles. `tx_drop` is high in the last of them, with no acceptance.
- `gnt`, `done`, `tx_drop`: one-hot or zero, and never high for two consecutive cycles.

## Test plan
- Single request: `req=3'b001`, a=8'h05, b=8'h03, op=ADD. Required: `gnt=001` one cycle after sampling, `alu_ena` in the same cycle, `done=001` next cycle, `result=16'h0008`, no `tx_valid` (TX_MASK bit 0 clear).
- Contention: `req=3'b111` held continuously from reset. Required: grants in order 0, 1, 2, 0, spaced 3 cycles apart for requester 0 and more when SEND intervenes. No requester is starved.
- TX forward: requester 2, a=8'h0F, b=8'h0F, op=ADD, `tx_ready` low for 4 cycles then high. Required: `tx_valid` high 5 cycles, `tx_data=8'h1E`, IDLE after acceptance.
- Timeout: `TX_TIMEOUT=8`, requester 1, `tx_ready` held low. Required: `tx_valid` high exactly 8 cycles, `tx_drop` pulse in the 8th, `busy` falls next cycle.
- `ena`/reset: `ena=0` with `req=3'b010` gives no `gnt` for 10 cycles; `ena=1` then gives a grant. `reset` asserted during EXEC gives no `done`, all outputs 0 and `ptr=0`; requester 0 wins next when `req=3'b111`.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer for the shared ALU.
// Three requesters (0 = switches, 1 = CPU core, 2 = UART parser) compete for
// one ALU. The winner's operands are registered, the ALU result is captured
// into a 16-bit result register and returned with a done pulse. Results of
// requesters selected by TX_MASK are also offered to the UART TX path over a
// valid/ready handshake that gives up after TX_TIMEOUT cycles.
module alu_arbiter #(
    parameter logic [2:0] TX_MASK    = 3'b110,
    parameter int         TX_TIMEOUT = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ena,
    input  logic [2:0]  req,
    input  logic [23:0] req_a,
    input  logic [23:0] req_b,
    input  logic [8:0]  req_op,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [15:0] result,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_opcode,
    output logic        alu_ena,
    input  logic [15:0] alu_result,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        tx_drop,
    output logic        busy
);

    // The timeout counter only ever needs to reach TX_TIMEOUT-1 (<= 1022).
    localparam int         CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        win_q, win_d;
    logic [7:0]        a_q, a_d;
    logic [7:0]        b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [15:0]       result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick_vld;
    logic [1:0]        pick_idx;
    logic              win_tx;
    logic              cnt_last;

    // Byte lane i of a packed 24-bit operand bus.
    function automatic logic [7:0] sel_byte(input logic [23:0] v, input logic [1:0] i);
        logic [7:0] r;
        case (i)
            2'd1:    r = v[15:8];
            2'd2:    r = v[23:16];
            default: r = v[7:0];
        endcase
        return r;
    endfunction

    // Opcode field i of the packed 9-bit opcode bus.
    function automatic logic [2:0] sel_op(input logic [8:0] v, input logic [1:0] i);
        logic [2:0] r;
        case (i)
            2'd1:    r = v[5:3];
            2'd2:    r = v[8:6];
            default: r = v[2:0];
        endcase
        return r;
    endfunction

    // One-hot encoding of a requester index (index 3 never occurs).
    function automatic logic [2:0] onehot3(input logic [1:0] i);
        logic [2:0] r;
        case (i)
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b001;
        endcase
        return r;
    endfunction

    // Successor of a requester index modulo 3.
    function automatic logic [1:0] next3(input logic [1:0] i);
        logic [1:0] r;
        case (i)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Round-robin search starting at the pointer: ptr, ptr+1, ptr+2 (mod 3).
    always_comb begin
        logic [1:0] cand;
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        cand     = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!pick_vld && ((req & onehot3(cand)) != 3'b000)) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
            cand = next3(cand);
        end
    end

    assign win_tx   = (TX_MASK & onehot3(win_q)) != 3'b000;
    assign cnt_last = (cnt_q == CNT_LAST);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ena only gates leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ena && pick_vld) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: state_d = win_tx ? S_SEND : S_IDLE;
            S_SEND: begin
                if (tx_ready || cnt_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand capture, result capture, TX wait counter.
    always_comb begin
        ptr_d    = ptr_q;
        win_d    = win_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ena && pick_vld) begin
                    win_d = pick_idx;
                    a_d   = sel_byte(req_a, pick_idx);
                    b_d   = sel_byte(req_b, pick_idx);
                    op_d  = sel_op(req_op, pick_idx);
                    ptr_d = next3(pick_idx);
                end
            end
            S_EXEC: result_d = alu_result;
            S_RESP: cnt_d = '0;
            S_SEND: begin
                if (!tx_ready && !cnt_last) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; everything clears on reset so all outputs read 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= 2'd0;
            win_q    <= 2'd0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'd0;
            result_q <= 16'h0000;
            cnt_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decoded from the current state and the registered winner.
    always_comb begin
        gnt      = 3'b000;
        done     = 3'b000;
        alu_ena  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_drop  = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_EXEC: begin
                gnt     = onehot3(win_q);
                alu_ena = 1'b1;
            end
            S_RESP: done = onehot3(win_q);
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = result_q[7:0];
                tx_drop  = !tx_ready && cnt_last;
            end
            default: ;
        endcase
    end

    assign result     = result_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;

endmodule
